// File: rtl/lsu_defs.sv
// Shared constants for the load/store unit: RISC-V funct3 access codes and FSM state encodings.
package lsu_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_RMW_WR = 1'b1;

endpackage

// File: rtl/lsu_load_align.sv
// Load formatting: selects the addressed byte/halfword of a memory word and sign- or zero-extends it.
module lsu_load_align
    import lsu_defs::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-only data memory.
// Sub-word stores are performed as a read-modify-write that stalls the core for one cycle.
module load_store_unit
    import lsu_defs::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_re,
    input  logic                  req_we,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic                  state;
    logic [DATA_WIDTH-1:0] merge_word;
    logic [ADDR_WIDTH-1:0] saved_addr;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  is_store;
    logic                  is_load;
    logic                  misaligned;
    logic                  store_ok;
    logic                  load_ok;
    logic                  rmw_start;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  unused_addr;

    // Upper address bits are dropped on purpose: accesses wrap modulo the memory size.
    assign word_addr   = addr[ADDR_WIDTH+1:2];
    assign unused_addr = &{1'b0, addr[31:ADDR_WIDTH+2]};

    assign is_store   = req_we;
    assign is_load    = req_re & ~req_we;
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign store_ok   = is_store && (funct3 inside {F3_B, F3_H, F3_W}) && !misaligned;
    assign load_ok    = is_load && (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) && !misaligned;
    assign rmw_start  = (state == ST_IDLE) && store_ok && (funct3 != F3_W);

    lsu_load_align u_load_align (
        .word   (mem_rdata),
        .offset (addr[1:0]),
        .funct3 (funct3),
        .data   (load_data)
    );

    always_comb begin
        merged = mem_rdata;
        if (funct3 == F3_B)
            merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
        else
            merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    end

    // NOTE: every output gets a default first, so no path through the case leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        rdata     = '0;
        stall     = 1'b0;
        fault     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            ST_RMW_WR: begin
                mem_we    = 1'b1;
                mem_addr  = saved_addr;
                mem_wdata = merge_word;
            end
            default: begin
                if (store_ok) begin
                    mem_addr = word_addr;
                    if (funct3 == F3_W) begin
                        mem_we    = 1'b1;
                        mem_wdata = wdata;
                    end else begin
                        mem_re = 1'b1;
                        stall  = 1'b1;
                    end
                end else if (load_ok) begin
                    mem_addr = word_addr;
                    mem_re   = 1'b1;
                    rdata    = load_data;
                end else if (is_store || is_load) begin
                    fault = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset also
    // clears the write-back path so a pending partial store is abandoned immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            merge_word <= '0;
            saved_addr <= '0;
        end else begin
            case (state)
                ST_RMW_WR: state <= ST_IDLE;
                default: begin
                    if (rmw_start) begin
                        state      <= ST_RMW_WR;
                        merge_word <= merged;
                        saved_addr <= word_addr;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written RMW/reset
// sequences, and randomized traffic checked against a byte-array memory model.
module tb_load_store_unit;
    import lsu_defs::*;

    localparam int AW = 4;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_re = 1'b0;
    logic          req_we = 1'b0;
    logic [2:0]    funct3 = 3'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          stall;
    logic          fault;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [31:0]   mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_re    (req_re),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .fault     (fault),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    // Word-wide data memory with combinational read; preload happens on a clock edge.
    logic [31:0] mem [NW];
    logic [31:0] preload_val [NW];
    logic        preload_req = 1'b0;

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < NW; i++) mem[i] <= preload_val[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];

    // Reference model: byte-addressed memory with little-endian lanes.
    logic [7:0] ref_mem [NW*4];

    function automatic logic [31:0] ref_word(int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    function automatic int ref_size(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_legal(bit st, logic [2:0] f3, logic [31:0] a);
        if (st && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b0;
        if (!st && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        return (a % ref_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
        logic [31:0] v;
        int n;
        int base;
        v    = '0;
        n    = ref_size(f3);
        base = int'(a % (NW*4));
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        int base;
        base = int'(a % (NW*4));
        for (int i = 0; i < ref_size(f3); i++) ref_mem[base+i] = 8'(wd >> (8*i));
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload();
        for (int w = 0; w < NW; w++) begin
            logic [31:0] val;
            val = (w == 1) ? 32'h8765_43A1 : $urandom;
            preload_val[w] = val;
            for (int b = 0; b < 4; b++) ref_mem[4*w+b] = 8'(val >> (8*b));
        end
        @(negedge clk);
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
    endtask

    // Present a request at the falling edge; outputs are sampled 2 time units later.
    task automatic drive(bit re, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
        @(negedge clk);
        req_re = re;
        req_we = we;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        #2;
    endtask

    task automatic hold();
        @(negedge clk);
        #2;
    endtask

    typedef struct {
        string       name;
        bit          re;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] exp_rdata;
        bit          exp_fault;
        bit          exp_mem_re;
        bit          exp_mem_we;
        logic [3:0]  exp_maddr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int stall_cnt;

        vecs.push_back('{"lb_4",     1'b1, 1'b0, 3'b000, 32'h04, 32'hFFFF_FFA1, 1'b0, 1'b1, 1'b0, 4'd1});
        vecs.push_back('{"lbu_7",    1'b1, 1'b0, 3'b100, 32'h07, 32'h0000_0087, 1'b0, 1'b1, 1'b0, 4'd1});
        vecs.push_back('{"lb_7",     1'b1, 1'b0, 3'b000, 32'h07, 32'hFFFF_FF87, 1'b0, 1'b1, 1'b0, 4'd1});
        vecs.push_back('{"lbu_5",    1'b1, 1'b0, 3'b100, 32'h05, 32'h0000_0043, 1'b0, 1'b1, 1'b0, 4'd1});
        vecs.push_back('{"lh_6",     1'b1, 1'b0, 3'b001, 32'h06, 32'hFFFF_8765, 1'b0, 1'b1, 1'b0, 4'd1});
        vecs.push_back('{"lhu_4",    1'b1, 1'b0, 3'b101, 32'h04, 32'h0000_43A1, 1'b0, 1'b1, 1'b0, 4'd1});
        vecs.push_back('{"lw_4",     1'b1, 1'b0, 3'b010, 32'h04, 32'h8765_43A1, 1'b0, 1'b1, 1'b0, 4'd1});
        vecs.push_back('{"lw_wrap",  1'b1, 1'b0, 3'b010, 32'h44, 32'h8765_43A1, 1'b0, 1'b1, 1'b0, 4'd1});
        vecs.push_back('{"sw_mis",   1'b0, 1'b1, 3'b010, 32'h06, 32'h0,         1'b1, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{"lh_mis",   1'b1, 1'b0, 3'b001, 32'h05, 32'h0,         1'b1, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{"ld_f3_011",1'b1, 1'b0, 3'b011, 32'h04, 32'h0,         1'b1, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{"st_f3_100",1'b0, 1'b1, 3'b100, 32'h04, 32'h0,         1'b1, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{"idle",     1'b0, 1'b0, 3'b010, 32'h04, 32'h0,         1'b0, 1'b0, 1'b0, 4'd0});

        // Reset state
        preload();
        #2;
        check("rst_rdata", rdata, 32'h0);
        check("rst_stall", stall, 32'h0);
        check("rst_fault", fault, 32'h0);
        check("rst_mem_we", mem_we, 32'h0);
        check("rst_mem_re", mem_re, 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle vectors
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].re, vecs[i].we, vecs[i].f3, vecs[i].a, 32'hDEAD_BEEF);
            check({vecs[i].name, "_rdata"},  rdata,            vecs[i].exp_rdata);
            check({vecs[i].name, "_fault"},  fault,            32'(vecs[i].exp_fault));
            check({vecs[i].name, "_mem_re"}, mem_re,           32'(vecs[i].exp_mem_re));
            check({vecs[i].name, "_mem_we"}, mem_we,           32'(vecs[i].exp_mem_we));
            check({vecs[i].name, "_stall"},  stall,            32'h0);
            check({vecs[i].name, "_maddr"},  32'(mem_addr),    32'(vecs[i].exp_maddr));
        end
        drive(0, 0, 3'b000, 0, 0);
        check("sw_mis_mem_unchanged", mem[1], 32'h8765_43A1);

        // SB read-modify-write
        preload();
        drive(0, 1, F3_B, 32'h05, 32'h1234_56CC);
        check("sb_c0_stall", stall, 32'h1);
        check("sb_c0_mem_re", mem_re, 32'h1);
        check("sb_c0_mem_we", mem_we, 32'h0);
        hold();
        check("sb_c1_mem_we", mem_we, 32'h1);
        check("sb_c1_maddr", 32'(mem_addr), 32'h1);
        check("sb_c1_wdata", mem_wdata, 32'h8765_CCA1);
        check("sb_c1_stall", stall, 32'h0);
        drive(1, 0, F3_W, 32'h04, 0);
        check("sb_lw_after", rdata, 32'h8765_CCA1);

        // SH followed immediately by a load
        preload();
        stall_cnt = 0;
        drive(0, 1, F3_H, 32'h06, 32'h0000_BEEF);
        stall_cnt += int'(stall);
        hold();
        stall_cnt += int'(stall);
        drive(1, 0, F3_W, 32'h04, 0);
        stall_cnt += int'(stall);
        check("sh_lw_after", rdata, 32'hBEEF_43A1);
        check("sh_stall_count", 32'(stall_cnt), 32'd1);

        // Reset during the write-back cycle
        preload();
        drive(0, 1, F3_B, 32'h04, 32'h0000_0055);
        hold();
        check("rmwrst_we_before", mem_we, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rmwrst_we_async", mem_we, 32'h0);
        req_re = 1'b0;
        req_we = 1'b0;
        #1;
        check("rmwrst_stall", stall, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rmwrst_mem_kept", mem[1], 32'h8765_43A1);
        drive(1, 0, F3_W, 32'h04, 0);
        check("rmwrst_lw", rdata, 32'h8765_43A1);
        check("rmwrst_idle_stall", stall, 32'h0);

        // Store wins over load
        drive(1, 1, F3_W, 32'h08, 32'h0000_0001);
        check("prio_rdata", rdata, 32'h0);
        check("prio_mem_we", mem_we, 32'h1);
        check("prio_maddr", 32'(mem_addr), 32'h2);
        drive(0, 0, 3'b000, 0, 0);
        check("prio_mem_word", mem[2], 32'h0000_0001);

        // Randomized traffic against the byte model
        preload();
        for (int n = 0; n < 400; n++) begin
            int          kind;
            bit          re;
            bit          we;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            kind = int'($urandom_range(0, 3));
            re   = (kind == 1) || (kind == 3);
            we   = (kind == 2) || (kind == 3);
            f3   = ($urandom_range(0, 9) < 8) ? 3'(($urandom_range(0, 4) == 4) ? 5 :
                   (($urandom_range(0, 3) == 3) ? 4 : $urandom_range(0, 2))) : 3'($urandom);
            a    = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(ref_size(f3) - 1);
            wd   = $urandom;
            drive(re, we, f3, a, wd);
            if (we) begin
                if (!ref_legal(1'b1, f3, a)) begin
                    check("rnd_st_fault", fault, 32'h1);
                    check("rnd_st_fault_we", mem_we, 32'h0);
                    check("rnd_st_fault_re", mem_re, 32'h0);
                    check("rnd_st_fault_stall", stall, 32'h0);
                end else if (f3 == F3_W) begin
                    check("rnd_sw_we", mem_we, 32'h1);
                    check("rnd_sw_wdata", mem_wdata, wd);
                    check("rnd_sw_maddr", 32'(mem_addr), 32'(a[5:2]));
                    check("rnd_sw_stall", stall, 32'h0);
                    ref_store(f3, a, wd);
                end else begin
                    check("rnd_rmw_c0_stall", stall, 32'h1);
                    check("rnd_rmw_c0_re", mem_re, 32'h1);
                    check("rnd_rmw_c0_we", mem_we, 32'h0);
                    ref_store(f3, a, wd);
                    hold();
                    check("rnd_rmw_c1_we", mem_we, 32'h1);
                    check("rnd_rmw_c1_maddr", 32'(mem_addr), 32'(a[5:2]));
                    check("rnd_rmw_c1_wdata", mem_wdata, ref_word(int'(a[5:2])));
                    check("rnd_rmw_c1_stall", stall, 32'h0);
                end
                check("rnd_st_rdata", rdata, 32'h0);
            end else if (re) begin
                if (ref_legal(1'b0, f3, a)) begin
                    check("rnd_ld_rdata", rdata, ref_load(f3, a));
                    check("rnd_ld_re", mem_re, 32'h1);
                    check("rnd_ld_fault", fault, 32'h0);
                end else begin
                    check("rnd_ld_fault", fault, 32'h1);
                    check("rnd_ld_fault_rdata", rdata, 32'h0);
                    check("rnd_ld_fault_re", mem_re, 32'h0);
                end
                check("rnd_ld_stall", stall, 32'h0);
            end else begin
                check("rnd_idle_rdata", rdata, 32'h0);
                check("rnd_idle_fault", fault, 32'h0);
                check("rnd_idle_re", mem_re, 32'h0);
                check("rnd_idle_we", mem_we, 32'h0);
            end
        end
        drive(0, 0, 3'b000, 0, 0);
        for (int w = 0; w < NW; w++) check("rnd_final_mem", mem[w], ref_word(w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
